// File: rtl/dll_tx_arbiter.sv
// Arbitrates ACK/NAK DLLPs, FC DLLPs and TLP beats onto the PIPE beat. Output is registered (1 cycle).
// Backpressure: TLP stalls via tlp_ready_o. DLLPs wait on their request levels until they get a one-cycle grant.
module dll_tx_arbiter #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int MAX_DLLP_BURST  = 4
) (
  input  logic                       sclk,
  input  logic                       srst,
  input  logic                       link_active_i,
  input  logic                       tlp_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  input  logic                       tlp_last_i,
  output logic                       tlp_ready_o,
  input  logic                       ack_req_i,
  input  logic [63:0]                ack_dllp_i,
  output logic                       ack_gnt_o,
  input  logic                       fc_req_i,
  input  logic [63:0]                fc_dllp_i,
  output logic                       fc_gnt_o,
  output logic [PIPE_DATA_WIDTH-1:0] dll2pipe_data_o,
  output logic                       dll2pipe_valid_o,
  output logic [1:0]                 dll2pipe_type_o
);

  typedef enum logic {
    ST_IDLE,
    ST_TLP
  } state_t;

  localparam logic [2:0] STARV_MAX = 3'(MAX_DLLP_BURST);
  localparam logic [1:0] TYPE_IDLE = 2'b00;
  localparam logic [1:0] TYPE_TLP  = 2'b01;
  localparam logic [1:0] TYPE_ACK  = 2'b10;
  localparam logic [1:0] TYPE_FC   = 2'b11;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [2:0]                 r_starv;
  logic [2:0]                 w_starv_nxt;
  logic                       w_tlp_elig;
  logic                       w_tlp_win;
  logic                       w_ack_gnt;
  logic                       w_fc_gnt;
  logic                       w_tlp_rdy;
  logic                       w_tlp_xfer;
  logic [PIPE_DATA_WIDTH-1:0] r_data;
  logic                       r_vld;
  logic [1:0]                 r_type;

  assign w_tlp_elig = link_active_i && tlp_valid_i;
  // Starvation guard: after a full DLLP burst the waiting TLP jumps the queue.
  assign w_tlp_win  = w_tlp_elig && ((r_starv == STARV_MAX) || (!ack_req_i && !fc_req_i));
  assign w_tlp_xfer = w_tlp_rdy && tlp_valid_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ack_gnt   = 1'b0;
    w_fc_gnt    = 1'b0;
    w_tlp_rdy   = 1'b0;
    if (!srst) begin
      case (r_state)
        ST_IDLE: begin
          w_tlp_rdy = w_tlp_win;
          w_ack_gnt = !w_tlp_win && ack_req_i;
          w_fc_gnt  = !w_tlp_win && !ack_req_i && fc_req_i;
          if (w_tlp_win && !tlp_last_i) begin
            w_state_nxt = ST_TLP;
          end
        end
        ST_TLP: begin
          w_tlp_rdy = link_active_i;
          // Link loss abandons the partial TLP; upstream flushes it.
          if (!link_active_i) begin
            w_state_nxt = ST_IDLE;
          end else if (tlp_valid_i && tlp_last_i) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_starv_nxt = r_starv;
    if (w_tlp_xfer || !w_tlp_elig) begin
      w_starv_nxt = 3'd0;
    end else if ((w_ack_gnt || w_fc_gnt) && (r_starv != 3'd7)) begin
      w_starv_nxt = r_starv + 3'd1;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_state <= ST_IDLE;
      r_starv <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_starv <= w_starv_nxt;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_type <= TYPE_IDLE;
    end else if (w_ack_gnt) begin
      r_data <= {{(PIPE_DATA_WIDTH-64){1'b0}}, ack_dllp_i};
      r_vld  <= 1'b1;
      r_type <= TYPE_ACK;
    end else if (w_fc_gnt) begin
      r_data <= {{(PIPE_DATA_WIDTH-64){1'b0}}, fc_dllp_i};
      r_vld  <= 1'b1;
      r_type <= TYPE_FC;
    end else if (w_tlp_xfer) begin
      r_data <= tlp_data_i;
      r_vld  <= 1'b1;
      r_type <= TYPE_TLP;
    end else begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_type <= TYPE_IDLE;
    end
  end

  assign tlp_ready_o      = w_tlp_rdy;
  assign ack_gnt_o        = w_ack_gnt;
  assign fc_gnt_o         = w_fc_gnt;
  assign dll2pipe_data_o  = r_data;
  assign dll2pipe_valid_o = r_vld;
  assign dll2pipe_type_o  = r_type;

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Scoreboard bench for dll_tx_arbiter: stimulus queues expected beats, a monitor pops and compares them.
module tb_dll_tx_arbiter;
  localparam int PW = 256;
  localparam int MB = 4;

  typedef logic [PW+1:0] beat_t;

  logic          sclk = 1'b0;
  logic          srst;
  logic          link_active_i;
  logic          tlp_valid_i;
  logic [PW-1:0] tlp_data_i;
  logic          tlp_last_i;
  logic          tlp_ready_o;
  logic          ack_req_i;
  logic [63:0]   ack_dllp_i;
  logic          ack_gnt_o;
  logic          fc_req_i;
  logic [63:0]   fc_dllp_i;
  logic          fc_gnt_o;
  logic [PW-1:0] dll2pipe_data_o;
  logic          dll2pipe_valid_o;
  logic [1:0]    dll2pipe_type_o;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  dll_tx_arbiter #(.PIPE_DATA_WIDTH(PW), .MAX_DLLP_BURST(MB)) dut (
    .sclk(sclk), .srst(srst), .link_active_i(link_active_i),
    .tlp_valid_i(tlp_valid_i), .tlp_data_i(tlp_data_i), .tlp_last_i(tlp_last_i),
    .tlp_ready_o(tlp_ready_o), .ack_req_i(ack_req_i), .ack_dllp_i(ack_dllp_i),
    .ack_gnt_o(ack_gnt_o), .fc_req_i(fc_req_i), .fc_dllp_i(fc_dllp_i),
    .fc_gnt_o(fc_gnt_o), .dll2pipe_data_o(dll2pipe_data_o),
    .dll2pipe_valid_o(dll2pipe_valid_o), .dll2pipe_type_o(dll2pipe_type_o)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input beat_t act, input beat_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t dllp_beat(input logic [1:0] t, input logic [63:0] b);
    return {t, {(PW-64){1'b0}}, b};
  endfunction

  function automatic logic [PW-1:0] tlpd(input int n);
    logic [31:0] w;
    w = 32'h5A5A_0000 | 32'(n);
    return {(PW/32){w}};
  endfunction

  // One arbitration cycle: check grants mid-cycle, queue the beat that must appear next cycle.
  task automatic cyc(input string name, input logic e_ack, input logic e_fc, input logic e_tlp);
    @(negedge sclk);
    check(name, beat_t'({ack_gnt_o, fc_gnt_o, tlp_ready_o & tlp_valid_i}), beat_t'({e_ack, e_fc, e_tlp}));
    if (e_ack) exp_q.push_back(dllp_beat(2'b10, ack_dllp_i));
    if (e_fc)  exp_q.push_back(dllp_beat(2'b11, fc_dllp_i));
    if (e_tlp) exp_q.push_back({2'b01, tlp_data_i});
    @(posedge sclk);
    #1;
  endtask

  always @(negedge sclk) begin
    if (!srst) begin
      if (dll2pipe_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got type %0d, expected no beat", dll2pipe_type_o);
        end else begin
          check("out_beat", {dll2pipe_type_o, dll2pipe_data_o}, exp_q.pop_front());
        end
      end else begin
        check("idle_beat", {dll2pipe_type_o, dll2pipe_data_o}, '0);
      end
    end
  end

  initial begin
    srst          = 1'b1;
    link_active_i = 1'b1;
    tlp_valid_i   = 1'b1;
    tlp_data_i    = tlpd(99);
    tlp_last_i    = 1'b1;
    ack_req_i     = 1'b1;
    ack_dllp_i    = 64'hACAC_0000_0000_0001;
    fc_req_i      = 1'b1;
    fc_dllp_i     = 64'hFCFC_0000_0000_0001;
    #12;
    check("rst_gnts", beat_t'({ack_gnt_o, fc_gnt_o, tlp_ready_o}), '0);
    check("rst_out", {dll2pipe_type_o, dll2pipe_data_o}, '0);
    check("rst_vld", beat_t'(dll2pipe_valid_o), '0);
    ack_req_i   = 1'b0;
    fc_req_i    = 1'b0;
    tlp_valid_i = 1'b0;
    @(posedge sclk);
    #1;
    srst = 1'b0;

    // All three requesters together: ACK, then FC, then TLP.
    ack_req_i = 1'b1; fc_req_i = 1'b1; tlp_valid_i = 1'b1; tlp_last_i = 1'b1; tlp_data_i = tlpd(1);
    cyc("all3_ack", 1'b1, 1'b0, 1'b0);
    ack_req_i = 1'b0;
    cyc("all3_fc", 1'b0, 1'b1, 1'b0);
    fc_req_i = 1'b0;
    cyc("all3_tlp", 1'b0, 1'b0, 1'b1);
    tlp_valid_i = 1'b0;
    cyc("all3_quiet", 1'b0, 1'b0, 1'b0);

    // ACK arriving mid-TLP waits for the last beat.
    tlp_valid_i = 1'b1; tlp_last_i = 1'b0; tlp_data_i = tlpd(10);
    cyc("mid_b0", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(11); ack_req_i = 1'b1; ack_dllp_i = 64'hACAC_0000_0000_0010;
    cyc("mid_b1", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(12); tlp_last_i = 1'b1;
    cyc("mid_b2", 1'b0, 1'b0, 1'b1);
    tlp_valid_i = 1'b0;
    cyc("mid_ack", 1'b1, 1'b0, 1'b0);
    ack_req_i = 1'b0;
    cyc("mid_quiet", 1'b0, 1'b0, 1'b0);

    // Starvation: four ACK grants, one TLP, then ACK resumes.
    ack_req_i = 1'b1; tlp_valid_i = 1'b1; tlp_last_i = 1'b1; tlp_data_i = tlpd(20);
    for (int i = 0; i < 4; i++) begin
      ack_dllp_i = 64'hACAC_0000_0000_0100 + 64'(i);
      cyc("starv_ack", 1'b1, 1'b0, 1'b0);
    end
    cyc("starv_tlp", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(21); ack_dllp_i = 64'hACAC_0000_0000_0200;
    cyc("starv_resume", 1'b1, 1'b0, 1'b0);
    ack_req_i = 1'b0; tlp_valid_i = 1'b0;
    cyc("starv_quiet", 1'b0, 1'b0, 1'b0);

    // Link down: DLLPs only, TLP never accepted.
    link_active_i = 1'b0; tlp_valid_i = 1'b1; tlp_data_i = tlpd(30);
    fc_req_i = 1'b1; fc_dllp_i = 64'hFCFC_0000_0000_0030;
    cyc("linkdn_fc", 1'b0, 1'b1, 1'b0);
    fc_req_i = 1'b0;
    cyc("linkdn_hold1", 1'b0, 1'b0, 1'b0);
    cyc("linkdn_hold2", 1'b0, 1'b0, 1'b0);
    tlp_valid_i = 1'b0; link_active_i = 1'b1;
    cyc("linkdn_quiet", 1'b0, 1'b0, 1'b0);

    // Two-cycle gap mid-TLP: idle beats, no FC interleaved.
    tlp_valid_i = 1'b1; tlp_last_i = 1'b0; tlp_data_i = tlpd(40);
    cyc("gap_b0", 1'b0, 1'b0, 1'b1);
    tlp_valid_i = 1'b0; fc_req_i = 1'b1; fc_dllp_i = 64'hFCFC_0000_0000_0040;
    cyc("gap_idle1", 1'b0, 1'b0, 1'b0);
    check("gap_out1_vld", beat_t'(dll2pipe_valid_o), '0);
    cyc("gap_idle2", 1'b0, 1'b0, 1'b0);
    check("gap_out2_vld", beat_t'(dll2pipe_valid_o), '0);
    tlp_valid_i = 1'b1; tlp_data_i = tlpd(41);
    cyc("gap_b1", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(42); tlp_last_i = 1'b1;
    cyc("gap_b2", 1'b0, 1'b0, 1'b1);
    tlp_valid_i = 1'b0;
    cyc("gap_fc", 1'b0, 1'b1, 1'b0);
    fc_req_i = 1'b0;
    cyc("gap_quiet", 1'b0, 1'b0, 1'b0);

    // Link drop mid-TLP returns to IDLE arbitration.
    tlp_valid_i = 1'b1; tlp_last_i = 1'b0; tlp_data_i = tlpd(50);
    cyc("drop_b0", 1'b0, 1'b0, 1'b1);
    link_active_i = 1'b0; tlp_data_i = tlpd(51);
    cyc("drop_nordy", 1'b0, 1'b0, 1'b0);
    link_active_i = 1'b1; fc_req_i = 1'b1; fc_dllp_i = 64'hFCFC_0000_0000_0050;
    tlp_last_i = 1'b1; tlp_data_i = tlpd(52);
    cyc("drop_idle_fc", 1'b0, 1'b1, 1'b0);
    fc_req_i = 1'b0;
    cyc("drop_tlp", 1'b0, 1'b0, 1'b1);
    tlp_valid_i = 1'b0;
    cyc("drop_quiet", 1'b0, 1'b0, 1'b0);

    // Reset during beat 2 of a TLP with FC pending.
    tlp_valid_i = 1'b1; tlp_last_i = 1'b0; tlp_data_i = tlpd(60);
    cyc("rstmid_b0", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(61);
    cyc("rstmid_b1", 1'b0, 1'b0, 1'b1);
    tlp_data_i = tlpd(62); tlp_last_i = 1'b1;
    fc_req_i = 1'b1; fc_dllp_i = 64'hFCFC_0000_0000_0060;
    @(negedge sclk);
    #1;
    srst = 1'b1;
    #1;
    check("rstmid_out", {dll2pipe_type_o, dll2pipe_data_o}, '0);
    check("rstmid_vld", beat_t'(dll2pipe_valid_o), '0);
    check("rstmid_gnts", beat_t'({ack_gnt_o, fc_gnt_o, tlp_ready_o}), '0);
    tlp_valid_i = 1'b0;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    #1;
    srst = 1'b0;
    #1;
    check("rstrel_fc", beat_t'({ack_gnt_o, fc_gnt_o, tlp_ready_o}), beat_t'(3'b010));
    exp_q.push_back(dllp_beat(2'b11, fc_dllp_i));
    @(posedge sclk);
    #1;
    fc_req_i = 1'b0;
    cyc("rstrel_quiet1", 1'b0, 1'b0, 1'b0);
    cyc("rstrel_quiet2", 1'b0, 1'b0, 1'b0);

    check("queue_empty", beat_t'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
